// File: rtl/dram_cmd_scheduler.sv
// rtl/dram_cmd_scheduler.sv - in-order open-page DRAM command scheduler
module dram_cmd_scheduler #(
  parameter int ADDRESS_WIDTH = 33,
  parameter int T_RCD   = 24,
  parameter int T_RP    = 24,
  parameter int T_RAS   = 52,
  parameter int T_CL    = 24,
  parameter int T_CWL   = 20,
  parameter int T_BURST = 4,
  parameter int T_RTP   = 12,
  parameter int T_WR    = 20
) (
  input  logic                     CPU_clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               opcode_in,
  input  logic [ADDRESS_WIDTH-1:0] address_in,
  output logic                     cmd_valid,
  output logic [1:0]               cmd,
  output logic [1:0]               cmd_bg,
  output logic [1:0]               cmd_bank,
  output logic [14:0]              cmd_row,
  output logic [10:0]              cmd_col,
  output logic                     done_s,
  output logic                     busy
);

  localparam logic [1:0] OP_DATA_WRITE = 2'd1;

  localparam logic [1:0] CMD_ACT = 2'd0;
  localparam logic [1:0] CMD_PRE = 2'd1;
  localparam logic [1:0] CMD_RD  = 2'd2;
  localparam logic [1:0] CMD_WR  = 2'd3;

  localparam int WR_HOLD = T_CWL + T_BURST + T_WR;
  localparam int RD_DONE = T_CL + T_BURST;
  localparam int WR_DONE = T_CWL + T_BURST;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_T = max2(max2(max2(T_RAS, WR_HOLD), max2(RD_DONE, WR_DONE)),
                              max2(max2(T_RCD, T_RP), T_RTP));
  localparam int CW = $clog2(MAX_T + 1);

  // Counters are loaded with N-1 on the issuing phase edge and checked for 0, so a
  // constraint of N DRAM cycles lands the next command exactly N phase edges later.
  localparam logic [CW-1:0] LD_RAS     = CW'(T_RAS - 1);
  localparam logic [CW-1:0] LD_RCD     = CW'(T_RCD - 1);
  localparam logic [CW-1:0] LD_RP      = CW'(T_RP - 1);
  localparam logic [CW-1:0] LD_RTP     = CW'(T_RTP - 1);
  localparam logic [CW-1:0] LD_WR_HOLD = CW'(WR_HOLD - 1);
  localparam logic [CW-1:0] LD_RD_DONE = CW'(RD_DONE - 1);
  localparam logic [CW-1:0] LD_WR_DONE = CW'(WR_DONE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_PRE,
    S_ACT,
    S_COL,
    S_WAIT_DONE
  } state_t;

  state_t state, state_nx;

  logic          phase;
  logic          req_wr;
  logic [3:0]    req_bank;
  logic [14:0]   req_row;
  logic [10:0]   req_col;

  logic [15:0]   open_valid;
  logic [14:0]   open_row [16];
  logic [CW-1:0] pre_wait [16];
  logic [CW-1:0] gap_cnt;
  logic [CW-1:0] done_cnt;

  logic          accept;
  logic          issue_pre;
  logic          issue_act;
  logic          issue_col;
  logic          finish;
  logic          row_open;
  logic          row_hit;
  logic [CW-1:0] pw_ticked;
  logic [CW-1:0] pw_col_ld;

  logic          unused_addr_bits;
  assign unused_addr_bits = ^address_in[2:0];

  function automatic logic [CW-1:0] tick(input logic [CW-1:0] v);
    return (v == '0) ? '0 : v - CW'(1);
  endfunction

  assign row_open  = open_valid[req_bank];
  assign row_hit   = row_open && (open_row[req_bank] == req_row);
  assign pw_ticked = tick(pre_wait[req_bank]);
  assign pw_col_ld = req_wr ? ((pw_ticked > LD_WR_HOLD) ? pw_ticked : LD_WR_HOLD)
                            : ((pw_ticked > LD_RTP) ? pw_ticked : LD_RTP);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge CPU_clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    issue_pre = 1'b0;
    issue_act = 1'b0;
    issue_col = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          accept   = 1'b1;
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        if (row_hit) begin
          state_nx = S_COL;
        end else if (!row_open) begin
          state_nx = S_ACT;
        end else begin
          state_nx = S_PRE;
        end
      end
      S_PRE: begin
        if (phase && (pre_wait[req_bank] == '0)) begin
          issue_pre = 1'b1;
          state_nx  = S_ACT;
        end
      end
      S_ACT: begin
        if (phase && (gap_cnt == '0)) begin
          issue_act = 1'b1;
          state_nx  = S_COL;
        end
      end
      S_COL: begin
        if (phase && (gap_cnt == '0)) begin
          issue_col = 1'b1;
          state_nx  = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (phase && (done_cnt == '0)) begin
          finish   = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CPU_clk or posedge rst) begin
    if (rst) begin
      phase      <= 1'b0;
      req_ready  <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd        <= 2'd0;
      cmd_bg     <= 2'd0;
      cmd_bank   <= 2'd0;
      cmd_row    <= 15'd0;
      cmd_col    <= 11'd0;
      done_s     <= 1'b0;
      req_wr     <= 1'b0;
      req_bank   <= 4'd0;
      req_row    <= 15'd0;
      req_col    <= 11'd0;
      open_valid <= '0;
      gap_cnt    <= '0;
      done_cnt   <= '0;
      for (int i = 0; i < 16; i++) begin
        open_row[i] <= '0;
        pre_wait[i] <= '0;
      end
    end else begin
      phase     <= ~phase;
      req_ready <= (state_nx == S_IDLE);
      cmd_valid <= issue_pre | issue_act | issue_col;
      done_s    <= finish;

      if (accept) begin
        req_wr   <= (opcode_in == OP_DATA_WRITE);
        req_row  <= address_in[32:18];
        req_col  <= {address_in[17:10], address_in[5:3]};
        req_bank <= {address_in[7:6], address_in[9:8]};
      end

      // One DRAM cycle elapses per phase=1 edge; issue loads below override the tick.
      if (phase) begin
        gap_cnt  <= tick(gap_cnt);
        done_cnt <= tick(done_cnt);
        for (int i = 0; i < 16; i++) begin
          pre_wait[i] <= tick(pre_wait[i]);
        end
      end

      if (issue_pre | issue_act | issue_col) begin
        cmd_bg   <= req_bank[3:2];
        cmd_bank <= req_bank[1:0];
      end

      if (issue_pre) begin
        cmd                  <= CMD_PRE;
        open_valid[req_bank] <= 1'b0;
        gap_cnt              <= LD_RP;
      end

      if (issue_act) begin
        cmd                  <= CMD_ACT;
        cmd_row              <= req_row;
        open_valid[req_bank] <= 1'b1;
        open_row[req_bank]   <= req_row;
        pre_wait[req_bank]   <= LD_RAS;
        gap_cnt              <= LD_RCD;
      end

      if (issue_col) begin
        cmd                <= req_wr ? CMD_WR : CMD_RD;
        cmd_col            <= req_col;
        pre_wait[req_bank] <= pw_col_ld;
        done_cnt           <= req_wr ? LD_WR_DONE : LD_RD_DONE;
      end
    end
  end

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// tb/tb_dram_cmd_scheduler.sv - table-driven scoreboard bench for dram_cmd_scheduler
module tb_dram_cmd_scheduler;

  localparam logic [1:0] OP_RD = 2'd0;
  localparam logic [1:0] OP_WR = 2'd1;
  localparam logic [1:0] OP_IF = 2'd2;

  localparam logic [1:0] C_ACT = 2'd0;
  localparam logic [1:0] C_PRE = 2'd1;
  localparam logic [1:0] C_RD  = 2'd2;
  localparam logic [1:0] C_WR  = 2'd3;

  localparam int K_HIT = 0;
  localparam int K_ACT = 1;
  localparam int K_PRE = 2;
  localparam int NV    = 7;

  logic        CPU_clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  opcode_in;
  logic [32:0] address_in;
  logic        cmd_valid;
  logic [1:0]  cmd;
  logic [1:0]  cmd_bg;
  logic [1:0]  cmd_bank;
  logic [14:0] cmd_row;
  logic [10:0] cmd_col;
  logic        done_s;
  logic        busy;

  dram_cmd_scheduler dut (
    .CPU_clk    (CPU_clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .opcode_in  (opcode_in),
    .address_in (address_in),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .cmd_bg     (cmd_bg),
    .cmd_bank   (cmd_bank),
    .cmd_row    (cmd_row),
    .cmd_col    (cmd_col),
    .done_s     (done_s),
    .busy       (busy)
  );

  initial CPU_clk = 1'b0;
  always #5 CPU_clk = ~CPU_clk;

  typedef struct {
    logic [1:0]  c;
    logic [1:0]  bg;
    logic [1:0]  bank;
    logic [14:0] row;
    logic [10:0] col;
  } cmd_t;

  typedef struct {
    logic [1:0]  op;
    logic [32:0] addr;
    int          kind;
    logic [1:0]  bg;
    logic [1:0]  bank;
    logic [14:0] row;
    logic [10:0] col;
    int          pre_exact;
  } vec_t;

  cmd_t exp_q[$];
  cmd_t e;
  vec_t vt[NV];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_cmd = 0;
  int n_done = 0;
  int n_acc = 0;
  int first_cmd = -1;
  int last_pre = 0;
  int last_act = 0;
  int last_col = 0;
  int done_at = 0;
  int act_at[16];
  int col_at[16];
  bit col_wr[16];

  always @(posedge CPU_clk) cyc <= cyc + 1;

  function automatic cmd_t mk(input logic [1:0] c, input logic [1:0] bg, input logic [1:0] bank,
                               input logic [14:0] row, input logic [10:0] col);
    cmd_t r;
    r.c = c; r.bg = bg; r.bank = bank; r.row = row; r.col = col;
    return r;
  endfunction

  function automatic vec_t mkv(input logic [1:0] op, input logic [32:0] addr, input int kind,
                               input logic [1:0] bg, input logic [1:0] bank, input logic [14:0] row,
                               input logic [10:0] col, input int pre_exact);
    vec_t v;
    v.op = op; v.addr = addr; v.kind = kind; v.bg = bg; v.bank = bank;
    v.row = row; v.col = col; v.pre_exact = pre_exact;
    return v;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_ge(input string name, input longint act, input longint min);
    checks++;
    if (act < min) begin
      errors++;
      $display("FAIL %s: got %0d expected >= %0d", name, act, min);
    end
  endtask

  // Scoreboard: every observed command is matched against the head of exp_q.
  always @(negedge CPU_clk) begin
    if (!rst) begin
      if (req_valid && req_ready) n_acc++;
      if (cmd_valid) begin
        n_cmd++;
        if (first_cmd < 0) first_cmd = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cmd_unexpected: got cmd %0d at cycle %0d expected none", cmd, cyc);
        end else begin
          e = exp_q.pop_front();
          check("cmd_type", cmd, e.c);
          check("cmd_bg", cmd_bg, e.bg);
          check("cmd_bank", cmd_bank, e.bank);
          if (e.c == C_ACT) check("cmd_row", cmd_row, e.row);
          if (e.c == C_RD || e.c == C_WR) check("cmd_col", cmd_col, e.col);
        end
        case (cmd)
          C_ACT: begin last_act = cyc; act_at[{cmd_bg, cmd_bank}] = cyc; end
          C_PRE: last_pre = cyc;
          default: begin
            last_col = cyc;
            col_at[{cmd_bg, cmd_bank}] = cyc;
            col_wr[{cmd_bg, cmd_bank}] = (cmd == C_WR);
          end
        endcase
      end
      if (done_s) begin
        n_done++;
        done_at = cyc;
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [32:0] a, output int acc);
    int n;
    n = 0;
    @(posedge CPU_clk); #1;
    while (!req_ready && n < 400) begin
      @(posedge CPU_clk); #1;
      n++;
    end
    check("req_ready_wait", req_ready, 1);
    opcode_in  = op;
    address_in = a;
    req_valid  = 1'b1;
    @(posedge CPU_clk); #1;
    acc       = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int n;
    n = 0;
    while (n_done == base && n < 600) begin
      @(negedge CPU_clk); #1;
      n++;
    end
    check("done_seen", n_done - base, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    int b;
    int p_act;
    int p_col;
    bit p_wr;
    int d0;
    int c0;
    int a0;
    int nd;
    int n;
    logic [1:0] cc;

    vt[0] = mkv(OP_RD, 33'h0_0004_0000, K_ACT, 2'd0, 2'd0, 15'd1, 11'd0,  -1);
    vt[1] = mkv(OP_RD, 33'h0_0004_0400, K_HIT, 2'd0, 2'd0, 15'd1, 11'd8,  -1);
    vt[2] = mkv(OP_WR, 33'h0_0008_0000, K_PRE, 2'd0, 2'd0, 15'd2, 11'd0,  -1);
    vt[3] = mkv(OP_RD, 33'h0_0014_02EB, K_ACT, 2'd3, 2'd2, 15'd5, 11'd5,  -1);
    vt[4] = mkv(OP_IF, 33'h0_0008_0C10, K_HIT, 2'd0, 2'd0, 15'd2, 11'd26, -1);
    vt[5] = mkv(OP_WR, 33'h0_0008_0008, K_HIT, 2'd0, 2'd0, 15'd2, 11'd1,  -1);
    vt[6] = mkv(OP_RD, 33'h0_000C_0000, K_PRE, 2'd0, 2'd0, 15'd3, 11'd0,  88);

    rst        = 1'b1;
    req_valid  = 1'b0;
    opcode_in  = OP_RD;
    address_in = '0;

    repeat (3) @(negedge CPU_clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd", cmd, 0);
    check("rst_cmd_bg", cmd_bg, 0);
    check("rst_cmd_bank", cmd_bank, 0);
    check("rst_cmd_row", cmd_row, 0);
    check("rst_cmd_col", cmd_col, 0);
    check("rst_done_s", done_s, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(posedge CPU_clk); #1;
    check("ready_after_rst", req_ready, 1);

    for (int i = 0; i < NV; i++) begin
      b     = {vt[i].bg, vt[i].bank};
      p_act = act_at[b];
      p_col = col_at[b];
      p_wr  = col_wr[b];
      d0    = n_done;
      c0    = n_cmd;
      cc    = (vt[i].op == OP_WR) ? C_WR : C_RD;
      if (vt[i].kind == K_PRE) exp_q.push_back(mk(C_PRE, vt[i].bg, vt[i].bank, 15'd0, 11'd0));
      if (vt[i].kind != K_HIT) exp_q.push_back(mk(C_ACT, vt[i].bg, vt[i].bank, vt[i].row, 11'd0));
      exp_q.push_back(mk(cc, vt[i].bg, vt[i].bank, 15'd0, vt[i].col));
      first_cmd = -1;
      send(vt[i].op, vt[i].addr, acc);
      wait_done(d0);
      check($sformatf("v%0d_ncmd", i), n_cmd - c0, vt[i].kind + 1);
      check_ge($sformatf("v%0d_accept_to_cmd", i), first_cmd - acc, 2);
      if (vt[i].kind != K_HIT) check($sformatf("v%0d_act_to_col", i), last_col - last_act, 48);
      if (vt[i].kind == K_PRE) begin
        check($sformatf("v%0d_pre_to_act", i), last_act - last_pre, 48);
        check_ge($sformatf("v%0d_act_to_pre", i), last_pre - p_act, 104);
        check_ge($sformatf("v%0d_col_to_pre", i), last_pre - p_col, p_wr ? 88 : 24);
        if (vt[i].pre_exact >= 0)
          check($sformatf("v%0d_col_to_pre_exact", i), last_pre - p_col, vt[i].pre_exact);
      end
      check($sformatf("v%0d_col_to_done", i), done_at - last_col, (cc == C_WR) ? 48 : 56);
      check($sformatf("v%0d_queue_empty", i), exp_q.size(), 0);
    end

    // Held req_valid across a busy period; the address changes while busy and must not be latched.
    d0 = n_done;
    a0 = n_acc;
    c0 = n_cmd;
    nd = 0;
    exp_q.push_back(mk(C_RD, 2'd0, 2'd0, 15'd0, 11'd16));
    exp_q.push_back(mk(C_RD, 2'd0, 2'd0, 15'd0, 11'd24));
    @(posedge CPU_clk); #1;
    n = 0;
    while (!req_ready && n < 400) begin
      @(posedge CPU_clk); #1;
      n++;
    end
    opcode_in  = OP_RD;
    address_in = 33'h0_000C_0800;
    req_valid  = 1'b1;
    @(posedge CPU_clk); #1;
    address_in = 33'h0_000C_0C00;
    n = 0;
    while (nd < 2 && n < 600) begin
      @(posedge CPU_clk); #1;
      n++;
      if (done_s) nd++;
    end
    req_valid = 1'b0;
    repeat (4) @(negedge CPU_clk);
    #1;
    check("hold_accepts", n_acc - a0, 2);
    check("hold_dones", n_done - d0, 2);
    check("hold_ncmd", n_cmd - c0, 2);
    check("hold_queue_empty", exp_q.size(), 0);
    check("hold_idle_busy", busy, 0);

    // Reset while waiting for read data.
    c0 = n_cmd;
    exp_q.push_back(mk(C_RD, 2'd0, 2'd0, 15'd0, 11'd0));
    send(OP_RD, 33'h0_000C_0000, acc);
    n = 0;
    while (n_cmd == c0 && n < 200) begin
      @(negedge CPU_clk); #1;
      n++;
    end
    check("abort_rd_issued", n_cmd - c0, 1);
    repeat (10) @(posedge CPU_clk);
    #1;
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_cmd_valid", cmd_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_req_ready", req_ready, 0);
    check("abort_done_s", done_s, 0);
    repeat (3) @(negedge CPU_clk);
    rst = 1'b0;
    d0 = n_done;
    repeat (80) @(negedge CPU_clk);
    #1;
    check("abort_no_done", n_done - d0, 0);

    c0 = n_cmd;
    exp_q.push_back(mk(C_ACT, 2'd0, 2'd0, 15'd3, 11'd0));
    exp_q.push_back(mk(C_RD, 2'd0, 2'd0, 15'd0, 11'd0));
    send(OP_RD, 33'h0_000C_0000, acc);
    wait_done(d0);
    check("post_rst_ncmd", n_cmd - c0, 2);
    check("post_rst_act_to_col", last_col - last_act, 48);
    check("post_rst_col_to_done", done_at - last_col, 56);
    check("post_rst_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_cmd_scheduler.md
# dram_cmd_scheduler

In-order DRAM command scheduler between the memory request queue and the DRAM command bus. It accepts one parsed memory request at a time through a valid/ready handshake and decodes its address into bank group, bank, row and column. It then tracks the open row of all 16 banks (open-page policy) and issues PRE/ACT/RD/WR commands with all timing constraints met. DRAM timing runs at half the CPU clock.

## Interface
- ADDRESS_WIDTH, 33 (from global_defs): request address width
- T_RCD, 24: ACT→RD/WR, DRAM cycles
- T_RP, 24: PRE→ACT, DRAM cycles
- T_RAS, 52: ACT→PRE, DRAM cycles
- T_CL, 24: RD→data end offset, DRAM cycles
- T_CWL, 20: WR→data end offset, DRAM cycles
- T_BURST, 4: burst length, DRAM cycles
- T_RTP, 12: RD→PRE, DRAM cycles
- T_WR, 20: write recovery after burst end, DRAM cycles
- CPU_clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request available on opcode_in/address_in
- req_ready  out  1  scheduler can accept a request
- opcode_in  in  parsed_op_t  data read / data write / instruction fetch
- address_in  in  ADDRESS_WIDTH  byte address
- cmd_valid  out  1  one-CPU-cycle command strobe
- cmd  out  2  0=ACT, 1=PRE, 2=RD, 3=WR
- cmd_bg  out  2  bank group
- cmd_bank  out  2  bank
- cmd_row  out  15  row (valid for ACT)
- cmd_col  out  11  column (valid for RD/WR)
- done_s  out  1  one-cycle strobe: current request complete
- busy  out  1  request in flight

## Operation
- Address map: row=[32:18], col={[17:10],[5:3]}, bank=[9:8], bg=[7:6], [2:0] ignored. Bank index = {bg,bank}.
- Data read and instruction fetch issue RD. Data write issues WR.
- Handshake: transfer on a CPU_clk edge with req_valid && req_ready. The request is latched, and req_ready drops the next cycle.
- FSM states:
  - IDLE → DECODE on accept.
  - DECODE → COL on a row hit (bank open, same row).
  - DECODE → ACT if the bank is closed.
  - DECODE → PRE on a row miss.
  - PRE → ACT after PRE issues.
  - ACT → COL after ACT issues.
  - COL → WAIT_DONE after RD/WR issues.
  - WAIT_DONE → IDLE on done_s.
- A command leaves its state only when it is issued. Issue happens on the first phase=1 cycle on which every constraint below is satisfied.
- Open-row table: 16 × {valid,row}. Reset invalidates all entries. ACT sets the entry, PRE clears it.
- Per-bank pre_wait down-counter, in DRAM cycles, saturating at 0:
  - ACT loads T_RAS.
  - RD loads max(current, T_RTP).
  - WR loads max(current, T_CWL+T_BURST+T_WR).
  - PRE is legal only at 0.
- Global gap counter enforces T_RP (PRE→ACT) and T_RCD (ACT→RD/WR).
- done_s fires T_CL+T_BURST DRAM cycles after RD, or T_CWL+T_BURST after WR. done_s and the return to IDLE happen on the same edge.
- Counter widths are sized for the largest parameter sum plus 1. No wrap occurs.
- busy = state≠IDLE.

## Timing
- Reset values:
  - state IDLE, phase 0, all counters 0, all banks closed.
  - req_ready=0, cmd_valid=0, cmd/cmd_bg/cmd_bank/cmd_row/cmd_col=0.
  - done_s=0, busy=0.
- req_ready is registered. It goes to 1 on the first edge after rst deasserts, and on the edge where done_s fires.
- The phase register toggles every CPU_clk. Commands issue only on phase=1 edges, so one DRAM cycle = 2 CPU cycles.
- Every counter decrements once per DRAM cycle, on phase=1 edges.
- A constraint of N DRAM cycles places the next command exactly 2N CPU cycles after the previous one when nothing else blocks it.
- cmd and its address fields are valid only while cmd_valid=1. Otherwise they hold their last value.
- Minimum accept→first command: 2 CPU cycles (DECODE, then the phase-aligned issue).
- Rules at boundaries:
  - req_valid while busy: ignored, not latched. The requester holds it.
  - rst asserted mid-operation: return to reset values immediately, abort the in-flight request with no done_s, and close all banks.
  - T_RAS and T_RTP/T_WR both pending on a miss: PRE waits for the larger.
  - Back-to-back hits to the same row: no ACT or PRE. Only RD/WR is issued, at ≥2 CPU cycles after accept.

## Test plan
- Reset, then a read to 0x0_0004_0000 (row 1, bank 0, bg 0):
  - req_ready=1 one cycle after release.
  - ACT row 1, then RD col 0 exactly 48 CPU cycles later.
  - done_s exactly 56 CPU cycles after RD.
- Hit: after the above, a read to 0x0_0004_0400 (col 8):
  - No ACT/PRE.
  - RD col 8 issued.
  - done_s 56 CPU cycles after RD.
- Miss: next, a write to 0x0_0008_0000 (row 2, same bank):
  - PRE issued no earlier than 104 CPU cycles after the ACT and no earlier than 24 after the last RD.
  - ACT row 2 exactly 48 after PRE.
  - WR exactly 48 after ACT.
  - done_s 48 after WR.
- Write then miss to row 3:
  - PRE ≥88 CPU cycles after WR (44 DRAM cycles).
- Independent banks: a read to bg 3, bank 2, row 5 while bank 0 has row 2 open.
  - ACT issues without a PRE.
  - Bank 0 stays open, so a later bank-0 row-2 access hits.
- Assert rst during WAIT_DONE of a read:
  - cmd_valid=0 and done_s never fires.
  - The next request to the previously open row gets ACT (all banks closed).
  - Hold req_valid=1 during busy: exactly one accept per done_s.
